uart_tx: RTL and testbench

Parameterised UART transmitter: serialises a `WIDTH`-bit word as start bit, data LSB first, optional parity, and stop bit. The line is idle-high. It sits on the sample-clock domain beside the matching receiver, which samples at `SAMPLES` clocks per bit. An internal pulser sub-module divides the clock to the bit rate, so both ends share one clock and one `SAMPLES` value.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_pulser.sv | 36 +++
 rtl/uart_tx.sv | 146 ++++++++++++++
 tb/tb_uart_tx.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the matching receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Frame sequencer states. PARITY is only visited when the transmitter is
  // built with UART_TX_PARITY_EN; the receiver uses the same encoding.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  // Level of the serial line between frames (and the stop bit).
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_pulser.sv
// Bit-rate pulser: free-running 0..SAMPLES-1 counter with a tick on the last count.
// Latency: tick is a decode of the registered count; clear takes effect on the next edge.
// Backpressure: none; runs every clock.
//
// Ports:
//   clk   - sample clock
//   reset - asynchronous, active-high; count returns to 0
//   clear - synchronous restart of the count at 0 (aligns a new bit period)
//   tick  - high for the final clock of each bit period
module pulser #(
  parameter int SAMPLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(SAMPLES);
  localparam logic [CW-1:0] LAST = CW'(SAMPLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Latency: tx leaves idle one clock after acceptance; frame lasts (WIDTH+2)*SAMPLES clocks (+SAMPLES with parity).
// Backpressure: ready is low for the whole frame; send is ignored while busy and accepted on the first idle cycle.
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// Ports:
//   clk   - sample clock (SAMPLES clocks per bit)
//   reset - asynchronous, active-high; abandons any frame in flight
//   send  - level request; accepted on a rising edge while ready is high
//   data  - word to send, captured only at acceptance
//   tx    - registered serial line, idle high
//   ready - registered, high only in IDLE
module uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SAMPLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             send,
  input  logic [WIDTH-1:0] data,
  output logic             tx,
  output logic             ready
);

  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  uart_state_t      state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [IW-1:0]    idx, idx_n;
  logic             tx_n, ready_n;
  logic             clear;
  logic             tick;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_n;
`endif

  pulser #(
    .SAMPLES(SAMPLES)
  ) u_pulser (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  // tx and ready are computed for the next state and registered, so the
  // line never glitches and both change on the same edge as the state.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    idx_n   = idx;
    tx_n    = tx;
    ready_n = ready;
    clear   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    case (state)
      ST_IDLE: begin
        tx_n    = UART_IDLE_LEVEL;
        ready_n = 1'b1;
        if (send) begin
          shreg_n = data;
          idx_n   = '0;
          clear   = 1'b1;  // bit period starts right after this edge
          state_n = ST_START;
          tx_n    = ~UART_IDLE_LEVEL;
          ready_n = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_n   = ^data;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_n = ST_DATA;
          tx_n    = shreg[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_n = shreg >> 1;
          idx_n   = idx + 1'b1;
          if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_n = ST_PARITY;
            tx_n    = par_q;
`else
            state_n = ST_STOP;
            tx_n    = UART_IDLE_LEVEL;
`endif
          end else begin
            tx_n = shreg_n[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_n = ST_STOP;
          tx_n    = UART_IDLE_LEVEL;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          state_n = ST_IDLE;
          tx_n    = UART_IDLE_LEVEL;
          ready_n = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = UART_IDLE_LEVEL;
        ready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      shreg <= '0;
      idx   <= '0;
      tx    <= UART_IDLE_LEVEL;
      ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      idx   <= idx_n;
      tx    <= tx_n;
      ready <= ready_n;
`ifdef UART_TX_PARITY_EN
      par_q <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (WIDTH=4, SAMPLES=4).
// Reference: each accepted frame is a list of bit values, each held SAMPLES cycles.
// Stimulus: directed frame, busy-ignore, back-to-back, reset mid-frame, sweep, random.
module tb_uart_tx;

  localparam int W = 4;
  localparam int S = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = W + 3;
  localparam logic [7:0] PAT1010 = 8'b0101_0100; // 0,0,1,0,1,0,1
`else
  localparam int NB = W + 2;
  localparam logic [7:0] PAT1010 = 8'b0011_0100; // 0,0,1,0,1,1
`endif
  localparam int FL = NB * S;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         send = 1'b0;
  logic [W-1:0] data = '0;
  logic         tx;
  logic         ready;

  uart_tx #(.WIDTH(W), .SAMPLES(S)) dut (
    .clk  (clk),
    .reset(reset),
    .send (send),
    .data (data),
    .tx   (tx),
    .ready(ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fstart = 0;
  bit active = 1'b0;
  logic [W-1:0] fdata = '0;
  int lo_cnt = 0;
  logic [7:0] pat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bit b of a frame carrying d: start, data LSB first, [even parity], stop.
  function automatic logic exp_bit(input int b, input logic [W-1:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < W; i++) ones += int'(d[i]);
    if (b == 0) return 1'b0;
    if (b <= W) return d[b-1];
    if (b < NB - 1) return logic'(ones % 2);
    return 1'b1;
  endfunction

  // One clock: update the frame model at the edge, compare at the falling edge.
  task automatic step();
    int k;
    @(posedge clk);
    cyc++;
    if (reset) begin
      active = 1'b0;
    end else if (send && (!active || (cyc - 1 - fstart) >= FL)) begin
      active = 1'b1;
      fstart = cyc;
      fdata  = data;
    end
    @(negedge clk);
    k = cyc - fstart;
    if (active && k < FL) begin
      check("tx", 32'(tx), 32'(exp_bit(k / S, fdata)));
      check("ready", 32'(ready), 32'd0);
    end else begin
      check("tx_idle", 32'(tx), 32'd1);
      check("ready_idle", 32'(ready), 32'd1);
    end
    if (!ready) lo_cnt++;
  endtask

  initial begin
    #12;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step();

    // Single frame 1010, with a busy-time send of 4'hF that must be ignored.
    pat = '0;
    lo_cnt = 0;
    data = 4'b1010;
    send = 1'b1;
    step();
    send = 1'b0;
    for (int c = 1; c < FL + 4; c++) begin
      if (c == 8) begin
        send = 1'b1;
        data = 4'hF;
      end
      if (c == 9) send = 1'b0;
      step();
      if (c < FL && c % S == S / 2) pat[c / S] = tx;
    end
    check("frame_bits", 32'(pat), 32'(PAT1010));
    check("busy_len", lo_cnt, FL);

    // Back-to-back frames with send held high.
    lo_cnt = 0;
    data = 4'h3;
    send = 1'b1;
    for (int c = 0; c <= 2 * FL; c++) step();
    send = 1'b0;
    check("b2b_busy", lo_cnt, 2 * FL);
    repeat (FL + 2) step();

    // Reset mid-frame: outputs go idle without waiting for a clock edge.
    data = 4'b0110;
    send = 1'b1;
    step();
    send = 1'b0;
    repeat (9) step();
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_ready", 32'(ready), 32'd1);
    step();
    reset = 1'b0;
    repeat (FL + 2) step();

    // Sweep every word.
    for (int v = 0; v < 16; v++) begin
      data = W'(v);
      send = 1'b1;
      step();
      send = 1'b0;
      repeat (FL) step();
    end

    // Random requests and data changes.
    for (int i = 0; i < 1500; i++) begin
      send = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) data = W'($urandom);
      step();
    end
    send = 1'b0;
    repeat (FL + 2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
